mix_columns_engine: RTL and testbench

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

---
 rtl/mix_pkg.sv | 27 ++
 rtl/mix_column2.sv | 27 ++
 rtl/mix_columns_engine.sv | 122 ++++++++++++
 tb/tb_mix_columns_engine.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mix_pkg : GF(2^8) constants, mode encodings, FSM states, helpers |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package mix_pkg;

    localparam logic [7:0] GF_POLY  = 8'h1B;
    localparam logic       MODE_FWD = 1'b0;
    localparam logic       MODE_INV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] v);
        return xtime(v) ^ v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_column2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mix_column2 : combinational 2-byte column mix, forward/inverse   |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module mix_column2
    import mix_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       mode,
    output logic [7:0] a_out,
    output logic [7:0] b_out
);

    // Forward matrix [[2,3],[1,1]]; its GF(2^8) inverse is [[1,3],[1,2]].
    always_comb begin
        a_out = xtime(a) ^ mul3(b);
        b_out = a ^ b;
        if (mode == MODE_INV) begin
            a_out = a ^ mul3(b);
            b_out = a ^ xtime(b);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mix_columns_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mix_columns_engine : multi-cycle 2-row MixColumns with handshake |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module mix_columns_engine
    import mix_pkg::*;
#(
    parameter int NCOL  = 4,
    parameter int LANES = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16*NCOL-1:0]   in_data,
    input  logic                 in_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [16*NCOL-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int              C_CW   = $clog2(NCOL) + 1;
    localparam int              C_W    = 16 * NCOL;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(NCOL - LANES);
    localparam logic [C_CW-1:0] C_STEP = C_CW'(LANES);

    generate
        if ((LANES < 1) || (NCOL % LANES != 0)) begin : g_bad_cfg
            $error("mix_columns_engine: NCOL must be a multiple of LANES");
        end
    endgenerate

    state_t               r_state_q, w_state_d;
    logic [C_W-1:0]       r_blk_q,   w_blk_d;
    logic [C_W-1:0]       r_res_q,   w_res_d;
    logic                 r_mode_q,  w_mode_d;
    logic [C_CW-1:0]      r_cnt_q,   w_cnt_d;

    logic [LANES-1:0][7:0] w_a_in, w_b_in, w_a_out, w_b_out;

    // Counter only ever holds multiples of LANES up to C_LAST, so the
    // lane windows below always stay inside the block.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_a_in[l] = r_blk_q[8*(int'(r_cnt_q) + l) +: 8];
            w_b_in[l] = r_blk_q[8*(NCOL + int'(r_cnt_q) + l) +: 8];
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            mix_column2 u_mix (
                .a     (w_a_in[g]),
                .b     (w_b_in[g]),
                .mode  (r_mode_q),
                .a_out (w_a_out[g]),
                .b_out (w_b_out[g])
            );
        end
    endgenerate

    always_comb begin
        w_state_d = r_state_q;
        w_blk_d   = r_blk_q;
        w_res_d   = r_res_q;
        w_mode_d  = r_mode_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_blk_d   = in_data;
                    w_mode_d  = in_mode;
                    w_cnt_d   = '0;
                    w_state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    w_res_d[8*(int'(r_cnt_q) + l) +: 8]        = w_a_out[l];
                    w_res_d[8*(NCOL + int'(r_cnt_q) + l) +: 8] = w_b_out[l];
                end
                // Counter parks on the last window instead of wrapping.
                if (r_cnt_q == C_LAST) begin
                    w_state_d = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + C_STEP;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_blk_q   <= '0;
            r_res_q   <= '0;
            r_mode_q  <= MODE_FWD;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_blk_q   <= w_blk_d;
            r_res_q   <= w_res_d;
            r_mode_q  <= w_mode_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = (r_state_q == ST_DONE);
    assign busy      = (r_state_q != ST_IDLE);
    assign out_data  = r_res_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mix_columns_engine : scoreboard bench, 4x1 and 8x2 instances  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_mix_columns_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: NCOL=4, LANES=1
    logic [63:0]  in_data_a  = '0;
    logic         in_mode_a  = 1'b0;
    logic         in_valid_a = 1'b0;
    logic         in_ready_a;
    logic [63:0]  out_data_a;
    logic         out_valid_a;
    logic         out_ready_a = 1'b0;
    logic         busy_a;

    // Instance B: NCOL=8, LANES=2
    logic [127:0] in_data_b  = '0;
    logic         in_mode_b  = 1'b0;
    logic         in_valid_b = 1'b0;
    logic         in_ready_b;
    logic [127:0] out_data_b;
    logic         out_valid_b;
    logic         out_ready_b = 1'b0;
    logic         busy_b;

    mix_columns_engine #(.NCOL(4), .LANES(1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_mode(in_mode_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .busy(busy_a)
    );

    mix_columns_engine #(.NCOL(8), .LANES(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_mode(in_mode_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b)
    );

    typedef struct {
        logic [127:0] d;
        int           acc;
    } sb_t;

    logic [63:0] exp_a_q[$];
    sb_t         sb_q[$];

    // Reference: generic shift-and-add GF(2^8) multiply modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, xx, yy;
        p = 8'h00; xx = x; yy = y;
        for (int i = 0; i < 8; i++) begin
            if (yy[0]) p = p ^ xx;
            xx = xx[7] ? ((xx << 1) ^ 8'h1B) : (xx << 1);
            yy = yy >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] d, input logic m, input int ncol);
        logic [127:0] r;
        logic [7:0]   a, b;
        r = '0;
        for (int i = 0; i < ncol; i++) begin
            a = d[8*i +: 8];
            b = d[8*(ncol+i) +: 8];
            if (!m) begin
                r[8*i +: 8]        = gmul(8'h02, a) ^ gmul(8'h03, b);
                r[8*(ncol+i) +: 8] = a ^ b;
            end else begin
                r[8*i +: 8]        = a ^ gmul(8'h03, b);
                r[8*(ncol+i) +: 8] = a ^ gmul(8'h02, b);
            end
        end
        return r;
    endfunction

    // Stimulus helpers (no checking): all start and end at #1 after an edge.
    task automatic accept_a(input logic [63:0] d, input logic m);
        int           k;
        logic [127:0] e;
        k = 0;
        in_data_a = d; in_mode_a = m; in_valid_a = 1'b1;
        while (in_ready_a !== 1'b1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk);
        e = mix_ref({64'h0, d}, m, 4);
        exp_a_q.push_back(e[63:0]);
        #1;
        in_valid_a = 1'b0; in_mode_a = ~m; in_data_a = ~d;
    endtask

    task automatic wait_valid_a(output int lat);
        lat = 0;
        while (out_valid_a !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic drain_a();
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid_a = 1'b1; in_data_a = 64'h1234_5678_9ABC_DEF0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid_a = 1'b0;
        n_tests++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || busy_a !== 1'b0 || out_data_a !== 64'h0)
            begin n_fail++; $display("FAIL reset_state: rdy=%b vld=%b busy=%b data=%h, want 1 0 0 0", in_ready_a, out_valid_a, busy_a, out_data_a); end
        n_tests++;
        if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || busy_b !== 1'b0 || out_data_b !== 128'h0)
            begin n_fail++; $display("FAIL reset_state_b: rdy=%b vld=%b busy=%b", in_ready_b, out_valid_b, busy_b); end
    endtask

    task automatic test_directed();
        logic [63:0] vd[6];
        logic [63:0] ve[6];
        logic        vm[6];
        logic [63:0] e;
        int          lat;
        vd[0] = 64'h0000_0000_0000_0080; vm[0] = 1'b0; ve[0] = 64'h0000_0080_0000_001B;
        vd[1] = 64'h0000_0080_0000_001B; vm[1] = 1'b1; ve[1] = 64'h0000_0000_0000_0080;
        vd[2] = 64'h0101_0101_0101_0101; vm[2] = 1'b0; ve[2] = 64'h0000_0000_0101_0101;
        // a == b gives a' = 2a ^ 3a = a and b' = 0.
        vd[3] = 64'hFFFF_FFFF_FFFF_FFFF; vm[3] = 1'b0; ve[3] = 64'h0000_0000_FFFF_FFFF;
        vd[4] = 64'h0000_0001_0000_0000; vm[4] = 1'b0; ve[4] = 64'h0000_0001_0000_0003;
        vd[5] = 64'h0000_0001_0000_0003; vm[5] = 1'b1; ve[5] = 64'h0000_0001_0000_0000;
        for (int i = 0; i < 6; i++) begin
            accept_a(vd[i], vm[i]);
            wait_valid_a(lat);
            n_tests++;
            if (lat !== 4) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d edges, want 4", i, lat); end
            n_tests++;
            if (out_data_a !== ve[i]) begin n_fail++; $display("FAIL directed_const[%0d]: got %h, want %h", i, out_data_a, ve[i]); end
            e = (exp_a_q.size() != 0) ? exp_a_q.pop_front() : 64'hx;
            n_tests++;
            if (out_data_a !== e) begin n_fail++; $display("FAIL directed_model[%0d]: got %h, want %h", i, out_data_a, e); end
            drain_a();
            n_tests++;
            if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_fail++; $display("FAIL directed_drain[%0d]: rdy=%b vld=%b, want 1 0", i, in_ready_a, out_valid_a); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] held, e;
        int          lat;
        accept_a(64'hA5C3_1E77_0F90_42D8, 1'b0);
        wait_valid_a(lat);
        n_tests++;
        if (lat !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d, want 4", lat); end
        held = out_data_a;
        e = (exp_a_q.size() != 0) ? exp_a_q.pop_front() : 64'hx;
        n_tests++;
        if (held !== e) begin n_fail++; $display("FAIL bp_data: got %h, want %h", held, e); end
        for (int i = 0; i < 10; i++) begin
            in_valid_a = 1'(i % 2 == 0);
            in_data_a  = {$urandom, $urandom};
            in_mode_a  = 1'(i % 3 == 0);
            @(posedge clk); #1;
            n_tests++;
            if (out_data_a !== held || out_valid_a !== 1'b1 || in_ready_a !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold[%0d]: data=%h vld=%b rdy=%b, want %h 1 0", i, out_data_a, out_valid_a, in_ready_a, held); end
        end
        in_valid_a = 1'b1;
        drain_a();
        in_valid_a = 1'b0;
        n_tests++;
        if (in_ready_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL bp_after_drain: rdy=%b busy=%b, want 1 0", in_ready_a, busy_a); end
        accept_a(64'h0123_4567_89AB_CDEF, 1'b1);
        wait_valid_a(lat);
        e = (exp_a_q.size() != 0) ? exp_a_q.pop_front() : 64'hx;
        n_tests++;
        if (lat !== 4 || out_data_a !== e) begin n_fail++; $display("FAIL bp_next_block: lat=%0d data=%h, want 4 %h", lat, out_data_a, e); end
        drain_a();
    endtask

    task automatic test_reset_mid_busy();
        logic [63:0] e;
        int          lat, seen;
        accept_a(64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_a_q.delete();
        n_tests++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || out_data_a !== 64'h0 || busy_a !== 1'b0)
            begin n_fail++; $display("FAIL rst_busy_state: rdy=%b vld=%b data=%h busy=%b, want 1 0 0 0", in_ready_a, out_valid_a, out_data_a, busy_a); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid_a === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL rst_busy_ghost: out_valid seen %0d cycles, want 0", seen); end
        accept_a(64'h1357_9BDF_2468_ACE0, 1'b0);
        wait_valid_a(lat);
        e = (exp_a_q.size() != 0) ? exp_a_q.pop_front() : 64'hx;
        n_tests++;
        if (lat !== 4 || out_data_a !== e) begin n_fail++; $display("FAIL rst_busy_next: lat=%0d data=%h, want 4 %h", lat, out_data_a, e); end
        drain_a();
    endtask

    task automatic test_random_8x2();
        fork
            begin : producer
                logic [127:0] x, d, e;
                logic         xm, m;
                sb_t          s;
                int           k;
                x = '0; xm = 1'b0;
                for (int i = 0; i < 1000; i++) begin
                    if (i % 2 == 0) begin
                        x  = {$urandom, $urandom, $urandom, $urandom};
                        xm = 1'($urandom_range(0, 1));
                        d  = x; m = xm; e = mix_ref(x, xm, 8);
                    end else begin
                        // Feed the mixed block back in the opposite direction.
                        d = mix_ref(x, xm, 8); m = ~xm; e = x;
                    end
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    in_data_b = d; in_mode_b = m; in_valid_b = 1'b1; k = 0;
                    while (in_ready_b !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
                    @(posedge clk); #1;
                    s.d = e; s.acc = cyc;
                    sb_q.push_back(s);
                    in_valid_b = 1'b0; in_mode_b = ~m; in_data_b = ~d;
                end
            end
            begin : consumer
                int   got, guard, lat;
                logic pend;
                sb_t  s;
                got = 0; guard = 0; pend = 1'b0;
                while (got < 1000 && guard < 30000) begin
                    @(posedge clk); #1; guard++;
                    if (out_valid_b === 1'b1 && !pend) begin
                        pend = 1'b1;
                        got++;
                        n_tests++;
                        if (sb_q.size() == 0) begin
                            n_fail++; $display("FAIL rand_unexpected: output %0d with empty scoreboard", got);
                        end else begin
                            s = sb_q.pop_front();
                            lat = cyc - s.acc;
                            if (out_data_b !== s.d) begin n_fail++; $display("FAIL rand_data[%0d]: got %h, want %h", got, out_data_b, s.d); end
                            n_tests++;
                            if (lat !== 4) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d, want 4", got, lat); end
                        end
                    end
                    out_ready_b = ($urandom_range(0, 3) != 0);
                    if (out_valid_b === 1'b1 && out_ready_b) pend = 1'b0;
                end
                out_ready_b = 1'b0;
                n_tests++;
                if (got !== 1000) begin n_fail++; $display("FAIL rand_count: got %0d blocks, want 1000", got); end
            end
        join
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_busy();
        test_random_8x2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation timed out, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
